// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-logic types and default constants
// Purpose: state encoding for the magazine controller, default timing constants
//          and a helper that sizes the shared cycle timer.
// Ports:   none (package).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        COOLDOWN,
        RELOADING
    } mag_state_t;

    localparam int MAG_SIZE_DEF        = 3;
    localparam int COOLDOWN_CYCLES_DEF = 6_500_000;
    localparam int RELOAD_CYCLES_DEF   = 32_500_000;

    // Width that holds max(a,b)-1; never narrower than one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/magazine_ctrl_if.sv
// rtl/magazine_ctrl_if.sv - player input / ammo status bundle for the magazine controller
// Purpose: groups the game-side inputs and the ammo status outputs.
// Signals: game_enable, round_start, mouse_left, reload_req (to controller);
//          bullets_in_magazine[2:0], shot_fired, dry_fire, reloading (from controller).
// Modports: master drives the inputs (game logic / bench), slave is the controller.
interface magazine_ctrl_if;

    logic       game_enable;
    logic       round_start;
    logic       mouse_left;
    logic       reload_req;
    logic [2:0] bullets_in_magazine;
    logic       shot_fired;
    logic       dry_fire;
    logic       reloading;

    modport master (
        output game_enable, round_start, mouse_left, reload_req,
        input  bullets_in_magazine, shot_fired, dry_fire, reloading
    );

    modport slave (
        input  game_enable, round_start, mouse_left, reload_req,
        output bullets_in_magazine, shot_fired, dry_fire, reloading
    );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with a zero flag
// Purpose: shared phase timer; counts down while enabled and holds at zero.
// Ports:   clk, rst_n (sync active-low), clear (force to 0, highest priority),
//          load/load_value (preset), enable (decrement), done (count is 0).
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            // Saturates at zero so the timer never wraps.
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/magazine_ctrl.sv
// rtl/magazine_ctrl.sv - ammunition magazine controller for one gun
// Purpose: turns left-click edges into shot pulses, enforces refire lockout and
//          timed reload, refills the magazine at round start.
// Ports:   clk (pixel clock), rst_n (sync active-low),
//          bus (slave): game_enable, round_start, mouse_left, reload_req in;
//          bullets_in_magazine, shot_fired, dry_fire, reloading out (all registered).
module magazine_ctrl
    import game_pkg::*;
#(
    parameter int MAG_SIZE        = MAG_SIZE_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int RELOAD_CYCLES   = RELOAD_CYCLES_DEF,
    parameter bit AUTO_RELOAD     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    magazine_ctrl_if.slave    bus
);

    localparam int             TW          = timer_width(COOLDOWN_CYCLES, RELOAD_CYCLES);
    localparam logic [2:0]     MAG_FULL    = 3'(MAG_SIZE);
    localparam logic [TW-1:0]  COOL_LOAD   = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [TW-1:0]  RELOAD_LOAD = TW'(RELOAD_CYCLES - 1);

    mag_state_t state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       shot_q, shot_d;
    logic       dry_q, dry_d;
    logic       reloading_q, reloading_d;
    logic       left_q, left_d;

    logic          click;
    logic          tmr_clear;
    logic          tmr_load;
    logic [TW-1:0] tmr_load_value;
    logic          tmr_en;
    logic          tmr_done;

    assign click = bus.mouse_left & ~left_q;

    cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .enable     (tmr_en),
        .done       (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        shot_d         = 1'b0;
        dry_d          = 1'b0;
        left_d         = bus.mouse_left;
        tmr_clear      = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = COOL_LOAD;
        tmr_en         = 1'b0;

        if (!bus.game_enable) begin
            // Leaving the game abandons any cooldown or reload in flight.
            state_d   = IDLE;
            count_d   = MAG_FULL;
            tmr_clear = 1'b1;
        end else if ((state_q != IDLE) && bus.round_start) begin
            // Refill wins over a click arriving in the same cycle.
            state_d   = READY;
            count_d   = MAG_FULL;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = MAG_FULL;
                    state_d = READY;
                end
                READY: begin
                    if (click) begin
                        if (count_q != 3'd0) begin
                            count_d        = count_q - 3'd1;
                            shot_d         = 1'b1;
                            tmr_load       = 1'b1;
                            tmr_load_value = COOL_LOAD;
                            state_d        = COOLDOWN;
                        end else begin
                            dry_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                tmr_load       = 1'b1;
                                tmr_load_value = RELOAD_LOAD;
                                state_d        = RELOADING;
                            end
                        end
                    end else if (bus.reload_req && (count_q != MAG_FULL)) begin
                        tmr_load       = 1'b1;
                        tmr_load_value = RELOAD_LOAD;
                        state_d        = RELOADING;
                    end
                end
                COOLDOWN: begin
                    tmr_en = 1'b1;
                    if (tmr_done) begin
                        if ((count_q == 3'd0) && AUTO_RELOAD) begin
                            tmr_load       = 1'b1;
                            tmr_load_value = RELOAD_LOAD;
                            state_d        = RELOADING;
                        end else begin
                            state_d = READY;
                        end
                    end
                end
                RELOADING: begin
                    tmr_en = 1'b1;
                    if (click) begin
                        dry_d = 1'b1;
                    end
                    if (tmr_done) begin
                        count_d = MAG_FULL;
                        state_d = READY;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Registered from the next state so the flag tracks RELOADING exactly.
        reloading_d = (state_d == RELOADING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= MAG_FULL;
            shot_q      <= 1'b0;
            dry_q       <= 1'b0;
            reloading_q <= 1'b0;
            left_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shot_q      <= shot_d;
            dry_q       <= dry_d;
            reloading_q <= reloading_d;
            left_q      <= left_d;
        end
    end

    assign bus.bullets_in_magazine = count_q;
    assign bus.shot_fired          = shot_q;
    assign bus.dry_fire            = dry_q;
    assign bus.reloading           = reloading_q;

endmodule

// File: doc/magazine_ctrl.md
# magazine_ctrl

Game-logic block that owns the player's ammunition count for one gun. It turns left-click events into single-cycle shot pulses, enforces a refire lockout and a timed reload, and refills the magazine at round start. Its `bullets_in_magazine` output feeds the bullet-overlay draw stage directly. `shot_fired` feeds hit detection; `dry_fire` feeds audio/flash logic. It runs in the 65 MHz pixel-clock domain.

## Interface
Parameters:
- `MAG_SIZE`, 3, magazine capacity; must satisfy 1..7.
- `COOLDOWN_CYCLES`, 6_500_000, refire lockout after a shot (100 ms); must be ≥1.
- `RELOAD_CYCLES`, 32_500_000, reload duration (500 ms); must be ≥1.
- `AUTO_RELOAD`, 1, 1 = start reloading automatically when the magazine is empty.

Ports:
- `clk` in 1: pixel clock, 65 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `game_enable` in 1: the game is running.
- `round_start` in 1: one-cycle pulse that refills the magazine.
- `mouse_left` in 1: left-button level, already synchronous to `clk`.
- `reload_req` in 1: level request for a manual reload (right button).
- `bullets_in_magazine` out 3: current count, registered, range 0..MAG_SIZE.
- `shot_fired` out 1: one-cycle pulse for an accepted shot.
- `dry_fire` out 1: one-cycle pulse for a click while empty or while reloading.
- `reloading` out 1: high while in RELOADING.

## Operation
- FSM states (`mag_state_t`): IDLE, READY, COOLDOWN, RELOADING.
- `click` = `mouse_left & ~left_q`, where `left_q` is `mouse_left` registered. Only rising edges count; holding the button does not refire.
- Priority per clock edge, highest first: reset > `!game_enable` > `round_start` > `click` > `reload_req` > timer expiry.
- IDLE: count is held at MAG_SIZE. When `game_enable` is 1, go to READY on the next edge.
- READY:
  - `click` with count>0: count−1, `shot_fired`=1, load the timer with COOLDOWN_CYCLES−1, go to COOLDOWN.
  - `click` with count=0: `dry_fire`=1. If AUTO_RELOAD=0 the block stays in READY.
  - `reload_req` with count<MAG_SIZE: load the timer with RELOAD_CYCLES−1, go to RELOADING.
  - `reload_req` with count=MAG_SIZE: ignored.
- COOLDOWN:
  - Clicks are ignored; no pulse of any kind is produced.
  - `reload_req` is ignored.
  - The timer decrements each cycle. When it reaches 0: if count=0 and AUTO_RELOAD=1, load RELOAD_CYCLES−1 and go to RELOADING; otherwise go to READY.
- RELOADING:
  - A click produces `dry_fire`=1.
  - `reload_req` is ignored.
  - When the timer reaches 0: count←MAG_SIZE, go to READY.
- `round_start` in any state except IDLE: count←MAG_SIZE, timer cleared, go to READY. A `click` in the same cycle is discarded.
- `game_enable` low in any state: go to IDLE and set count←MAG_SIZE on the next edge. An in-flight cooldown or reload is abandoned.
- Timer: a single down-counter of width `$clog2(max(COOLDOWN_CYCLES,RELOAD_CYCLES))`. It never wraps; it holds at 0 outside COOLDOWN and RELOADING.
- The count never underflows below 0 or exceeds MAG_SIZE.

## Timing
- Reset values: state IDLE, `bullets_in_magazine`=MAG_SIZE, `shot_fired`=0, `dry_fire`=0, `reloading`=0, `left_q`=0, timer=0.
- Shot latency is 1 clock. If edge N samples `mouse_left`=1 with `left_q`=0, then after edge N `shot_fired`=1 for exactly one cycle and the count is already decremented.
- Cooldown length: the next click is accepted no earlier than edge N+COOLDOWN_CYCLES+1.
- Reload length: `reloading` is high for exactly RELOAD_CYCLES cycles. The count becomes MAG_SIZE in the same cycle that `reloading` falls.
- `shot_fired` and `dry_fire` are never high in the same cycle.
- All outputs are registered; no combinational path from input to output.
- Reset asserted mid-reload returns all state to the reset values at the next edge.

## Structure
- Shared `game_pkg` holds `mag_state_t` and the default constants `MAG_SIZE_DEF`, `COOLDOWN_CYCLES_DEF` and `RELOAD_CYCLES_DEF`.
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` flag and parameterised width. It is shared by the cooldown and reload phases.
- Edge detection and the FSM live inline in `magazine_ctrl`.

## Test plan
All scenarios use MAG_SIZE=3, COOLDOWN_CYCLES=4 and RELOAD_CYCLES=20.
- Reset, then `game_enable`=1: count=3 and `reloading`=0. One click gives a `shot_fired` pulse of exactly 1 cycle and count=2.
- Hold `mouse_left` high for 50 cycles: exactly one `shot_fired`, count=2.
- Three clicks spaced 10 cycles apart: counts 2, 1, 0. `reloading` rises 4 cycles after the third shot and stays high for 20 cycles, then count=3.
- Click during RELOADING: one `dry_fire`, no `shot_fired`, count unchanged. With AUTO_RELOAD=0, a click at count=0 gives `dry_fire` and the block stays in READY.
- Click 2 cycles after a shot (inside cooldown): no pulse, count unchanged. Assert `reload_req` at count=3: no reload starts.
- `round_start` together with a click at count=1 during RELOADING: count=3, state READY, no `shot_fired`. Drop `game_enable` mid-reload: `reloading`=0 and count=3 on the next edge.
